dbg_mailbox_ctrl: RTL and testbench

Hardware sequencer for the core's debug mailbox: it captures CPU stores into the 8-word debug argument RAM and, when the function word (word 0) is written, executes that debug command in hardware. Commands are halt, assert-equal, assert-not-equal and print-chars. Results go to pass/fail counters, a sticky error flag and a byte-stream console port. It sits in the memory stage beside the debug RAM, so self-checking programs can run on silicon or in a bench without hierarchical peeking.

---
 rtl/dbg_mailbox_ctrl.sv | 143 ++++++++++++++
 tb/tb_dbg_mailbox_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_mailbox_ctrl.sv
// Debug mailbox sequencer: captures CPU stores into the argument RAM and executes the
// command held in word 0 (halt, assert-eq, assert-ne, print) when that word is written.
module dbg_mailbox_ctrl #(
    parameter int unsigned ARG_WORDS = 8,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned AW       = $clog2(ARG_WORDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [AW-1:0]              addr,
    input  logic [31:0]                wdata,
    output logic                       stall,
    output logic [ARG_WORDS-1:0][31:0] args,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic                       err,
    output logic [31:0]                err_func,
    output logic                       cmd_done,
    output logic                       halted
);

    typedef enum logic [1:0] {StIdle, StDecode, StPrint, StHalted} state_e;

    state_e                     state_q, state_d;
    logic [ARG_WORDS-1:0][31:0] args_q;
    logic [1:0]                 idx_q, idx_d;
    logic [CNT_W-1:0]           pass_q, pass_d, fail_q, fail_d, pass_inc, fail_inc;
    logic                       err_q, err_d;
    logic [31:0]                err_func_q, err_func_d;
    logic                       halted_q, halted_d;
    logic                       cmd_done_q, cmd_done_d;
    logic                       accept;
    logic [7:0]                 cur_byte;

    // Args only change in IDLE, so a print in progress always sees a stable word.
    assign accept   = we && (state_q == StIdle);
    assign cur_byte = 8'(args_q[1] >> {idx_q, 3'b000});
    assign pass_inc = (&pass_q) ? pass_q : pass_q + CNT_W'(1);
    assign fail_inc = (&fail_q) ? fail_q : fail_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        err_d      = err_q;
        err_func_d = err_func_q;
        halted_d   = halted_q;
        cmd_done_d = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state_q)
            StIdle: begin
                if (accept && (addr == '0)) state_d = StDecode;
            end
            StDecode: begin
                state_d    = StIdle;
                cmd_done_d = 1'b1;
                case (args_q[0])
                    32'd0: begin
                        halted_d = 1'b1;
                        state_d  = StHalted;
                    end
                    32'd1: begin
                        if (args_q[1] == args_q[2]) pass_d = pass_inc;
                        else                        fail_d = fail_inc;
                    end
                    32'd2: begin
                        if (args_q[1] != args_q[2]) pass_d = pass_inc;
                        else                        fail_d = fail_inc;
                    end
                    32'd3: begin
                        idx_d      = 2'd0;
                        state_d    = StPrint;
                        cmd_done_d = 1'b0;
                    end
                    default: begin
                        if (!err_q) begin
                            err_d      = 1'b1;
                            err_func_d = args_q[0];
                        end
                    end
                endcase
            end
            StPrint: begin
                if (cur_byte == 8'h00) begin
                    state_d    = StIdle;
                    cmd_done_d = 1'b1;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = cur_byte;
                    if (tx_ready) begin
                        if (idx_q == 2'd3) begin
                            state_d    = StIdle;
                            cmd_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
            end
            default: ;  // StHalted: left only through reset
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            args_q     <= '0;
            idx_q      <= 2'd0;
            pass_q     <= '0;
            fail_q     <= '0;
            err_q      <= 1'b0;
            err_func_q <= 32'h0;
            halted_q   <= 1'b0;
            cmd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            err_func_q <= err_func_d;
            halted_q   <= halted_d;
            cmd_done_q <= cmd_done_d;
            if (accept) args_q[addr] <= wdata;
        end
    end

    assign stall    = we && (state_q != StIdle);
    assign args     = args_q;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err      = err_q;
    assign err_func = err_func_q;
    assign cmd_done = cmd_done_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_dbg_mailbox_ctrl.sv
// Randomized self-checking bench for dbg_mailbox_ctrl against a behavioural mailbox model.
// Counters are built 8 bits wide so saturation is reachable in a short run.
module tb_dbg_mailbox_ctrl;

    localparam int CW = 8;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic              clk, reset, we, tx_ready;
    logic [2:0]        addr;
    logic [31:0]       wdata;
    logic              stall, tx_valid, err, cmd_done, halted;
    logic [7:0][31:0]  args;
    logic [7:0]        tx_data;
    logic [CW-1:0]     pass_cnt, fail_cnt;
    logic [31:0]       err_func;

    int n_tests, n_fail;

    // Reference model state
    logic [31:0]   exp_args [8];
    int unsigned   exp_pass, exp_fail;
    logic          exp_err, exp_halted;
    logic [31:0]   exp_err_func;

    dbg_mailbox_ctrl #(.ARG_WORDS(8), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .stall    (stall),
        .args     (args),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .err      (err),
        .err_func (err_func),
        .cmd_done (cmd_done),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) exp_args[i] = 32'h0;
        exp_pass = 0; exp_fail = 0; exp_err = 0; exp_err_func = 0; exp_halted = 0;
    endfunction

    function automatic void model_cmd(input logic [31:0] code);
        if (code == 0) exp_halted = 1'b1;
        else if (code == 1 || code == 2) begin
            if ((code == 1) == (exp_args[1] == exp_args[2])) exp_pass = sat_inc(exp_pass);
            else exp_fail = sat_inc(exp_fail);
        end else if (code != 3 && !exp_err) begin
            exp_err = 1'b1;
            exp_err_func = code;
        end
    endfunction

    // CPU store; waits out stall (bounded) and returns just after the accepting edge.
    task automatic store(input logic [2:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        #1;
        while (stall && n < 64) begin
            @(negedge clk); #1; n++;
        end
        n_tests++;
        if (stall) begin
            n_fail++;
            $display("FAIL store_accept addr=%0d: stall=%b after %0d cycles, required 0", a, stall, n);
            we = 1'b0;
        end else begin
            @(posedge clk);
            #1 we = 1'b0;
            exp_args[a] = d;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({stall, tx_valid, tx_data, pass_cnt, fail_cnt, err, err_func, cmd_done, halted} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b txv=%b txd=%h pass=%0d fail=%0d err=%b func=%h done=%b halt=%b, required all 0",
                     stall, tx_valid, tx_data, pass_cnt, fail_cnt, err, err_func, cmd_done, halted);
        end
        n_tests++;
        if (args !== '0) begin
            n_fail++;
            $display("FAIL reset_args: got %h, required 0", args);
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_assert();
        logic [31:0] a1, a2, code;
        for (int i = 0; i < 24; i++) begin
            if (i == 0)      begin a1 = 5; a2 = 5; code = 1; end
            else if (i == 1) begin a1 = 5; a2 = 6; code = 1; end
            else if (i == 2) begin a1 = 5; a2 = 6; code = 2; end
            else begin
                a1 = $urandom;
                a2 = ($urandom_range(0, 1) == 1) ? a1 : $urandom;
                code = $urandom_range(1, 2);
            end
            store(3'd1, a1);
            store(3'd2, a2);
            store(3'd0, code);
            model_cmd(code);
            @(negedge clk);
            n_tests++;
            if (cmd_done !== 1'b0 || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL assert_decode_cycle #%0d: cmd_done=%b stall=%b, required 0 0", i, cmd_done, stall);
            end
            @(negedge clk);
            n_tests++;
            if (cmd_done !== 1'b1) begin
                n_fail++;
                $display("FAIL assert_cmd_done #%0d: cmd_done=%b, required 1", i, cmd_done);
            end
            n_tests++;
            if (pass_cnt !== CW'(exp_pass) || fail_cnt !== CW'(exp_fail)) begin
                n_fail++;
                $display("FAIL assert_counts #%0d code=%0d: pass=%0d fail=%0d, required pass=%0d fail=%0d",
                         i, code, pass_cnt, fail_cnt, exp_pass, exp_fail);
            end
        end
        for (int w = 0; w < 8; w++) begin
            n_tests++;
            if (args[3'(w)] !== exp_args[w]) begin
                n_fail++;
                $display("FAIL args_view word %0d: got %h, required %h", w, args[3'(w)], exp_args[w]);
            end
        end
    endtask

    task automatic test_err();
        logic [31:0] codes [3];
        codes[0] = 32'hDEAD;
        codes[1] = 32'd7;
        codes[2] = $urandom_range(4, 32'h7fff_ffff);
        for (int i = 0; i < 3; i++) begin
            store(3'd0, codes[i]);
            model_cmd(codes[i]);
            repeat (2) @(negedge clk);
            n_tests++;
            if (err !== exp_err || err_func !== exp_err_func || cmd_done !== 1'b1) begin
                n_fail++;
                $display("FAIL err_code #%0d: err=%b func=%h done=%b, required err=%b func=%h done=1",
                         i, err, err_func, cmd_done, exp_err, exp_err_func);
            end
            n_tests++;
            if (pass_cnt !== CW'(exp_pass) || fail_cnt !== CW'(exp_fail)) begin
                n_fail++;
                $display("FAIL err_counts #%0d: pass=%0d fail=%0d, required %0d %0d",
                         i, pass_cnt, fail_cnt, exp_pass, exp_fail);
            end
        end
    endtask

    // plan=1: stall sink 3 cycles on 'B' and issue a CPU store mid-print.
    task automatic run_print(input logic [31:0] w, input bit plan);
        logic [7:0] q [$];
        logic [7:0] prev;
        logic       rdy, held, done;
        int         got, low_cnt;
        logic [31:0] a5;
        for (int k = 0; k < 4; k++) begin
            if (w[k*8 +: 8] == 8'h00) break;
            q.push_back(w[k*8 +: 8]);
        end
        a5 = exp_args[5];
        store(3'd1, w);
        store(3'd0, 32'd3);
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL print_decode_valid: tx_valid=%b, required 0", tx_valid);
        end
        got = 0; held = 0; done = 0; low_cnt = 0; prev = 8'h00;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (c == 0 && q.size() > 0) begin
                n_tests++;
                if (tx_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL print_first_valid: tx_valid=%b, required 1", tx_valid);
                end
            end
            if (cmd_done) done = 1;
            else if (tx_valid) begin
                if (held) begin
                    n_tests++;
                    if (tx_data !== prev) begin
                        n_fail++;
                        $display("FAIL print_hold: tx_data=%h, required %h", tx_data, prev);
                    end
                end
                if (plan) begin
                    rdy = !(tx_data == 8'h42 && low_cnt < 3);
                    if (!rdy) begin
                        low_cnt++;
                        if (low_cnt == 2) begin
                            we = 1'b1; addr = 3'd5; wdata = $urandom;
                            #1;
                            n_tests++;
                            if (stall !== 1'b1) begin
                                n_fail++;
                                $display("FAIL print_cpu_stall: stall=%b, required 1", stall);
                            end
                        end
                    end else we = 1'b0;
                end else rdy = 1'($urandom_range(0, 1));
                tx_ready = rdy;
                if (rdy) begin
                    n_tests++;
                    if (got >= q.size() || tx_data !== q[got]) begin
                        n_fail++;
                        $display("FAIL print_byte %0d: tx_data=%h, required %h (%0d bytes expected)",
                                 got, tx_data, (got < q.size()) ? q[got] : 8'h00, q.size());
                    end
                    got++;
                    held = 0;
                end else begin
                    held = 1;
                    prev = tx_data;
                end
            end
        end
        we = 1'b0;
        tx_ready = 1'b1;
        n_tests++;
        if (!done || got != q.size()) begin
            n_fail++;
            $display("FAIL print_count w=%h: done=%b bytes=%0d, required done=1 bytes=%0d", w, done, got, q.size());
        end
        n_tests++;
        if (args[5] !== a5) begin
            n_fail++;
            $display("FAIL print_args_frozen: args[5]=%h, required %h", args[5], a5);
        end
    endtask

    task automatic test_print();
        logic [31:0] w;
        int z;
        run_print(32'h00434241, 1'b1);
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                z = $urandom_range(0, 3);
                w[z*8 +: 8] = 8'h00;
            end
            run_print(w, 1'b0);
        end
    endtask

    task automatic test_reset_mid_print();
        int n;
        store(3'd1, 32'h11223344);
        store(3'd0, 32'd3);
        tx_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 5) begin @(negedge clk); n++; end
        reset = 1'b0;
        #1;
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || args !== '0 || pass_cnt !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_print: txv=%b txd=%h pass=%0d err=%b, required all 0 (waited %0d)",
                     tx_valid, tx_data, pass_cnt, err, n);
        end
        @(negedge clk);
        reset = 1'b1;
        tx_ready = 1'b1;
        model_reset();
    endtask

    task automatic test_saturation();
        store(3'd1, 32'hCAFE_0001);
        store(3'd2, 32'hCAFE_0001);
        for (int i = 0; i < CMAX + 4; i++) begin
            store(3'd0, 32'd1);
            model_cmd(32'd1);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (pass_cnt !== CW'(exp_pass) || exp_pass != CMAX) begin
            n_fail++;
            $display("FAIL pass_saturate: pass=%0d, required %0d", pass_cnt, CMAX);
        end
        for (int i = 0; i < CMAX + 4; i++) begin
            store(3'd0, 32'd2);
            model_cmd(32'd2);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (fail_cnt !== CW'(exp_fail) || pass_cnt !== CW'(exp_pass)) begin
            n_fail++;
            $display("FAIL fail_saturate: fail=%0d pass=%0d, required %0d %0d",
                     fail_cnt, pass_cnt, exp_fail, exp_pass);
        end
    endtask

    task automatic test_halt();
        store(3'd0, 32'd0);
        model_cmd(32'd0);
        repeat (2) @(negedge clk);
        n_tests++;
        if (halted !== exp_halted || cmd_done !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_enter: halted=%b done=%b, required 1 1", halted, cmd_done);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            we = 1'b1; addr = 3'($urandom_range(0, 7)); wdata = $urandom;
            #1;
            n_tests++;
            if (stall !== 1'b1 || cmd_done !== 1'b0 || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_stall #%0d: stall=%b done=%b halted=%b, required 1 0 1", i, stall, cmd_done, halted);
            end
        end
        @(negedge clk);
        n_tests++;
        if (args[addr] !== exp_args[addr]) begin
            n_fail++;
            $display("FAIL halt_args_frozen: args[%0d]=%h, required %h", addr, args[addr], exp_args[addr]);
        end
        reset = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({stall, tx_valid, tx_data, pass_cnt, fail_cnt, err, err_func, cmd_done, halted} !== '0
            || args !== '0) begin
            n_fail++;
            $display("FAIL halt_reset: stall=%b pass=%0d fail=%0d err=%b halted=%b, required all 0",
                     stall, pass_cnt, fail_cnt, err, halted);
        end
        we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'h0; tx_ready = 1'b1;
        n_tests = 0; n_fail = 0;
        model_reset();
        test_reset();
        test_assert();
        test_err();
        test_print();
        test_reset_mid_print();
        test_saturation();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
